ray_memory_cached: RTL
======================

Name: ray_memory_cached

Overview:
- Next-generation ray memory client for the raytracer.
- Walks the octree for a query position and returns the leaf depth and material word; also performs single-word pixel writes to the framebuffer.
- Adds three things: a direct-mapped node cache with working flush, a bounded maximum traversal depth with an error flag, and saturating hit/miss counters.
- Sits between the ray stepper and the shared MemoryBus as one bus master.

Parameters:
- POSITION_WIDTH, 16, width of each position coordinate.
- DATA_WIDTH, 24, bus data word width.
- ADDRESS_WIDTH, 32, bus address width.
- MASTER_ID, 0, value driven on msID and matched against smID.
- MATERIAL_ADDRESS_WIDTH, 8, low bits of a leaf word used as the material index.
- MAX_DEPTH, 8, maximum tree levels walked; must be ≤ POSITION_WIDTH and ≤ 15.
- CACHE_INDEX_WIDTH, 4, node cache holds 2^CACHE_INDEX_WIDTH entries.
- COUNT_WIDTH, 16, width of the hit and miss counters.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- materialAddress  in  ADDRESS_WIDTH  material table base; static while in use
- treeAddress  in  ADDRESS_WIDTH  octree base; static while in use
- flush  in  1  invalidate all cache entries; honoured only while ready
- traverse  in  1  start traversal; sampled only while ready
- position  in  3 x POSITION_WIDTH  query point [2:0]; held stable until done
- writePixel  in  1  start pixel write; sampled only while ready
- pixel  in  24  pixel value, zero-extended to DATA_WIDTH
- pixelAddress  in  ADDRESS_WIDTH  pixel target address
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse when a traversal finishes
- error  out  1  valid with done; set when MAX_DEPTH is exceeded
- depth  out  4  leaf level; root = 0
- material  out  DATA_WIDTH  leaf material word
- hitCount  out  COUNT_WIDTH  saturating count of node cache hits
- missCount  out  COUNT_WIDTH  saturating count of node cache misses
- bus  MemoryBus.Master  shared memory bus (ms*/sm* signals)

Behaviour:
- Reset values: state IDLE; msValid 0; smTaken 0; done 0; error 0; depth 0; material 0; both counters 0; all cache valid bits 0. ready = 1 in the first cycle after reset.
- States: IDLE, PIXEL_REQ, LOOKUP, NODE_REQ, NODE_WAIT, MAT_REQ, MAT_WAIT.
- IDLE priority when commands coincide:
  - flush clears all valid bits that cycle and does not block a command.
  - If writePixel and traverse are both high, writePixel wins and traverse is dropped.
- Pixel write: load msAddress = pixelAddress, msData = pixel, msWrite = 1, go to PIXEL_REQ. Return to IDLE in the cycle after msTaken.
- Traversal registers: level L = 0, node index N = 0.
- Per-level address:
  - octant = {position[2][PW-1-L], position[1][PW-1-L], position[0][PW-1-L]}.
  - Word offset K = {N, octant}; node address = treeAddress + zero-extend(K).
- Cache indexing: index = K[CACHE_INDEX_WIDTH-1:0]; tag = remaining K bits.
- LOOKUP, one cycle per level:
  - Hit (valid and tag match): use the cached word, increment hitCount, evaluate the word in the same cycle.
  - Miss: increment missCount, go to NODE_REQ with msWrite = 0.
- NODE_REQ → NODE_WAIT on msTaken. In NODE_WAIT, on an accepted response: write the word into the cache, then evaluate it.
- Word evaluation:
  - Leaf when word[DATA_WIDTH-1 : MATERIAL_ADDRESS_WIDTH] is all ones. Then depth = L, msAddress = materialAddress + zero-extend(word[MATERIAL_ADDRESS_WIDTH-1:0]), go to MAT_REQ.
  - Otherwise, if L == MAX_DEPTH-1: error = 1, material = 0, depth = L, pulse done, go to IDLE.
  - Otherwise: N = word, L = L+1, go to LOOKUP.
- MAT_REQ → MAT_WAIT on msTaken. In MAT_WAIT, on response: material = smData, error = 0, pulse done, go to IDLE. Material words are never cached.
- Bus handshake:
  - msValid = 1 exactly in PIXEL_REQ, NODE_REQ and MAT_REQ.
  - msAddress, msData and msWrite are stable while msValid is high.
  - msID = MASTER_ID at all times.
  - smTaken = (state is NODE_WAIT or MAT_WAIT) && smValid && smID == MASTER_ID. Responses carrying a foreign ID are never taken.
- Counters saturate at all ones and clear only on reset.
- depth, material and error hold their values until the next done.
- flush while not ready is ignored.
- Reset mid-operation returns to IDLE immediately and clears the cache. A late response for the abandoned request is not taken.
- Latency: a traversal that hits at every level and has a zero-wait material read takes (levels + 2) cycles from LOOKUP to done.

Test Plan:
- Pixel write: writePixel with pixel=24'h123456, pixelAddress=0x100, msTaken delayed 3 cycles → msValid held 4 cycles with msWrite=1 and msData=0x123456; ready returns the cycle after acceptance.
- Root leaf: treeAddress=0x1000, materialAddress=0x2000, all positions 0x8000:
  - Node read at 0x1007 returns 0xFFFF05; material read at 0x2005 returns 0xABCDEF.
  - Expect material=0xABCDEF, depth=0, error=0, one done pulse, missCount=1.
- Two levels then hit:
  - Root word at 0x1007 returns 0x000002; level-1 read at 0x1010 returns 0xFFFF01.
  - Expect depth=1, missCount=2. Repeating the same traverse issues only the material read and gives hitCount=2.
- Flush: flush in IDLE, then repeat the two-level traverse → two node reads again, missCount=4.
- Depth limit: MAX_DEPTH=2 and every node word is 0x000001 → error=1, depth=1, material=0, no material read issued.
- Robustness:
  - smValid with smID≠MASTER_ID during NODE_WAIT → smTaken=0 and no state change.
  - reset asserted in NODE_WAIT → ready=1 next cycle and a subsequent traverse misses.

Source files
------------

// File: rtl/ray_memory_cached.sv
// rtl/ray_memory_cached.sv - octree-walking ray memory client with node cache, depth limit and hit/miss counters
module ray_memory_cached #(
    parameter int POSITION_WIDTH         = 16,
    parameter int DATA_WIDTH             = 24,
    parameter int ADDRESS_WIDTH          = 32,
    parameter int ID_WIDTH               = 4,
    parameter int MASTER_ID              = 0,
    parameter int MATERIAL_ADDRESS_WIDTH = 8,
    parameter int MAX_DEPTH              = 8,
    parameter int CACHE_INDEX_WIDTH      = 4,
    parameter int COUNT_WIDTH            = 16
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [ADDRESS_WIDTH-1:0]             materialAddress,
    input  logic [ADDRESS_WIDTH-1:0]             treeAddress,
    input  logic                                 flush,
    input  logic                                 traverse,
    input  logic [2:0][POSITION_WIDTH-1:0]       position,
    input  logic                                 writePixel,
    input  logic [23:0]                          pixel,
    input  logic [ADDRESS_WIDTH-1:0]             pixelAddress,
    output logic                                 ready,
    output logic                                 done,
    output logic                                 error,
    output logic [3:0]                           depth,
    output logic [DATA_WIDTH-1:0]                material,
    output logic [COUNT_WIDTH-1:0]               hitCount,
    output logic [COUNT_WIDTH-1:0]               missCount,
    output logic                                 msValid,
    input  logic                                 msTaken,
    output logic [ADDRESS_WIDTH-1:0]             msAddress,
    output logic [DATA_WIDTH-1:0]                msData,
    output logic                                 msWrite,
    output logic [ID_WIDTH-1:0]                  msID,
    input  logic                                 smValid,
    output logic                                 smTaken,
    input  logic [DATA_WIDTH-1:0]                smData,
    input  logic [ID_WIDTH-1:0]                  smID
);

    localparam int KEY_WIDTH = DATA_WIDTH + 3;
    localparam int TAG_WIDTH = KEY_WIDTH - CACHE_INDEX_WIDTH;
    localparam int ENTRIES   = 1 << CACHE_INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        PIXEL_REQ,
        LOOKUP,
        NODE_REQ,
        NODE_WAIT,
        MAT_REQ,
        MAT_WAIT
    } state_t;

    state_t state, state_next;

    logic [3:0]            level;
    logic [DATA_WIDTH-1:0] node;

    logic [ENTRIES-1:0]    cache_valid;
    logic [TAG_WIDTH-1:0]  cache_tag  [ENTRIES];
    logic [DATA_WIDTH-1:0] cache_data [ENTRIES];

    logic [POSITION_WIDTH-1:0]    pos_x, pos_y, pos_z;
    logic [2:0]                   octant;
    logic [KEY_WIDTH-1:0]         key;
    logic [CACHE_INDEX_WIDTH-1:0] cache_index;
    logic [TAG_WIDTH-1:0]         cache_key_tag;
    logic                         cache_hit;
    logic                         resp_ok;
    logic                         eval_now;
    logic [DATA_WIDTH-1:0]        eval_word;
    logic                         is_leaf;
    logic                         last_level;
    logic [ADDRESS_WIDTH-1:0]     node_address;
    logic [ADDRESS_WIDTH-1:0]     leaf_material_address;

    // Shifting by the level brings the bit for this tree level to the MSB.
    assign pos_x  = position[0] << level;
    assign pos_y  = position[1] << level;
    assign pos_z  = position[2] << level;
    assign octant = {pos_z[POSITION_WIDTH-1], pos_y[POSITION_WIDTH-1], pos_x[POSITION_WIDTH-1]};

    assign key           = {node, octant};
    assign cache_index   = key[CACHE_INDEX_WIDTH-1:0];
    assign cache_key_tag = key[KEY_WIDTH-1:CACHE_INDEX_WIDTH];
    assign node_address  = treeAddress + ADDRESS_WIDTH'(key);
    assign cache_hit     = cache_valid[cache_index] && (cache_tag[cache_index] == cache_key_tag);

    assign resp_ok  = smValid && (smID == ID_WIDTH'(MASTER_ID));
    assign smTaken  = ((state == NODE_WAIT) || (state == MAT_WAIT)) && resp_ok;
    assign msValid  = (state == PIXEL_REQ) || (state == NODE_REQ) || (state == MAT_REQ);
    assign msID     = ID_WIDTH'(MASTER_ID);
    assign ready    = (state == IDLE);

    // A node word is evaluated either straight from the cache or from the bus response.
    assign eval_word  = (state == NODE_WAIT) ? smData : cache_data[cache_index];
    assign eval_now   = ((state == LOOKUP) && cache_hit) || ((state == NODE_WAIT) && resp_ok);
    assign is_leaf    = &eval_word[DATA_WIDTH-1:MATERIAL_ADDRESS_WIDTH];
    assign last_level = (level == 4'(MAX_DEPTH - 1));
    assign leaf_material_address = materialAddress + ADDRESS_WIDTH'(eval_word[MATERIAL_ADDRESS_WIDTH-1:0]);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (writePixel) begin
                    state_next = PIXEL_REQ;
                end else if (traverse) begin
                    state_next = LOOKUP;
                end
            end
            PIXEL_REQ: if (msTaken) state_next = IDLE;
            LOOKUP:    if (!cache_hit) state_next = NODE_REQ;
            NODE_REQ:  if (msTaken) state_next = NODE_WAIT;
            MAT_REQ:   if (msTaken) state_next = MAT_WAIT;
            MAT_WAIT:  if (resp_ok) state_next = IDLE;
            default:   state_next = state;
        endcase
        if (eval_now) begin
            if (is_leaf) begin
                state_next = MAT_REQ;
            end else if (last_level) begin
                state_next = IDLE;
            end else begin
                state_next = LOOKUP;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            level       <= '0;
            node        <= '0;
            msAddress   <= '0;
            msData      <= '0;
            msWrite     <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            depth       <= '0;
            material    <= '0;
            hitCount    <= '0;
            missCount   <= '0;
            cache_valid <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        cache_valid <= '0;
                    end
                    if (writePixel) begin
                        msAddress <= pixelAddress;
                        msData    <= DATA_WIDTH'(pixel);
                        msWrite   <= 1'b1;
                    end else if (traverse) begin
                        level <= '0;
                        node  <= '0;
                    end
                end
                LOOKUP: begin
                    if (cache_hit) begin
                        if (hitCount != '1) hitCount <= hitCount + 1'b1;
                    end else begin
                        if (missCount != '1) missCount <= missCount + 1'b1;
                        msAddress <= node_address;
                        msWrite   <= 1'b0;
                    end
                end
                NODE_WAIT: begin
                    if (resp_ok) cache_valid[cache_index] <= 1'b1;
                end
                MAT_WAIT: begin
                    if (resp_ok) begin
                        material <= smData;
                        error    <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (eval_now) begin
                if (is_leaf) begin
                    depth     <= level;
                    msAddress <= leaf_material_address;
                    msWrite   <= 1'b0;
                end else if (last_level) begin
                    error    <= 1'b1;
                    material <= '0;
                    depth    <= level;
                    done     <= 1'b1;
                end else begin
                    node  <= eval_word;
                    level <= level + 4'd1;
                end
            end
        end
    end

    // Tag/data storage carries no reset; the valid bits alone decide a hit.
    always_ff @(posedge clock) begin
        if (!reset && (state == NODE_WAIT) && resp_ok) begin
            cache_tag[cache_index]  <= cache_key_tag;
            cache_data[cache_index] <= smData;
        end
    end

endmodule
